// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with debounced up/down duty buttons.
// Duty changes are staged in a target register and only take effect at a period boundary.

module pwm_channel #(
    parameter int CNT_W = 8,
    parameter int PERIOD = 10,
    parameter int STEP = 1,
    parameter int INIT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] target,
    output logic             pwm
);
    localparam logic [CNT_W:0]   PER_X  = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0] PER_V  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT);

    logic [CNT_W-1:0] active;
    logic [CNT_W:0]   tgt_x;
    logic [CNT_W:0]   up;
    logic [CNT_W-1:0] dn;

    // one extra bit so saturation is decided before any wrap can happen
    assign tgt_x = {1'b0, target};
    assign up    = tgt_x + STEP_X;
    assign dn    = target - STEP_V;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      target <= INIT_V;
        else if (inc) target <= (up > PER_X) ? PER_V : up[CNT_W-1:0];
        else if (dec) target <= (tgt_x < STEP_X) ? '0 : dn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       active <= INIT_V;
        else if (load) active <= target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm <= 1'b0;
        else     pwm <= en & (cnt < active);
    end
endmodule

module pwm_multi_channel #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 10,
    parameter int STEP      = 1,
    parameter int DEB_DIV   = 25000000,
    parameter int INIT_DUTY = 5,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                increase_duty,
    input  logic                decrease_duty,
    input  logic [CH_W-1:0]     ch_sel,
    output logic [CNT_W-1:0]    duty_out,
    output logic                period_start,
    output logic [CHANNELS-1:0] PWM_OUT
);
    localparam int               DIV_W    = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam int               INIT_C   = (INIT_DUTY > PERIOD) ? PERIOD : INIT_DUTY;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       btn, s1, s2, press;
    logic             inc_ev, dec_ev;
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic [CHANNELS-1:0][CNT_W-1:0] target;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // rising edge seen at the sample tick -> one event per press, however long it is held
    assign btn = {decrease_duty, increase_duty};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else if (tick) begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    assign press  = s1 & ~s2 & {2{tick}};
    assign inc_ev = press[0] & ~press[1];
    assign dec_ev = press[1] & ~press[0];

    assign wrap = en & (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt <= '0;
        else if (!en || wrap) cnt <= '0;
        else                  cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) period_start <= 1'b0;
        else     period_start <= en & (cnt == '0);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W),
            .PERIOD(PERIOD),
            .STEP  (STEP),
            .INIT  (INIT_C)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .load  (wrap | ~en),
            .inc   (inc_ev & (ch_sel == CH_W'(i))),
            .dec   (dec_ev & (ch_sel == CH_W'(i))),
            .cnt   (cnt),
            .target(target[i]),
            .pwm   (PWM_OUT[i])
        );
    end

    // out-of-range selects match no channel and read back as 0
    always_comb begin
        duty_out = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (ch_sel == CH_W'(i)) duty_out = target[i];
    end
endmodule
